// File: rtl/approx_mul_pkg.sv
// ---------------------------------------------------------------------------
// approx_mul_pkg
// Shared definitions for the approximate multiplier pipeline:
//   - mul_mode_e    : per-transaction product mode (exact / approximate)
//   - approx_mul_ref: behavioural reference of the lower-part-OR product,
//                     intended for benches and assertion checkers only.
// ---------------------------------------------------------------------------
package approx_mul_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mul_mode_e;

  localparam int REF_MAX_W = 32;

  // Column-by-column model: columns at or above k are summed exactly, columns
  // below k (approximate mode only) collapse to the OR of their partial
  // products and never produce a carry.
  function automatic logic [63:0] approx_mul_ref(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic        mode,
    input int          k,
    input int          w
  );
    logic [63:0] hi;
    logic [63:0] lo;
    int          kk;
    hi = 64'd0;
    lo = 64'd0;
    kk = (mode == MODE_APPROX) ? k : 0;
    for (int i = 0; i < REF_MAX_W; i++) begin
      for (int j = 0; j < REF_MAX_W; j++) begin
        if ((i < w) && (j < w) && (a[i] & b[j])) begin
          if ((i + j) >= kk) begin
            hi = hi + (64'd1 << (i + j));
          end else begin
            lo[i+j] = 1'b1;
          end
        end
      end
    end
    return hi | lo;
  endfunction

endpackage

// File: rtl/approx_col_reduce.sv
// ---------------------------------------------------------------------------
// approx_col_reduce
// Combinational partial-product stage of the approximate multiplier.
// Builds the WIDTH shifted partial-product rows, OR-compresses the low
// APPROX_COLS columns when approximate mode is selected, and reduces the
// remaining (exact) columns to a two-row carry-save form.
// Ports:
//   i_a, i_b  : unsigned operands (WIDTH)
//   i_mode    : 0 exact, 1 approximate
//   o_lo      : OR-compressed low columns (0 in exact mode)   (2*WIDTH)
//   o_sum     : carry-save sum row of the exact columns       (2*WIDTH)
//   o_carry   : carry-save carry row of the exact columns     (2*WIDTH)
// ---------------------------------------------------------------------------
module approx_col_reduce
  import approx_mul_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_mode,
  output logic [2*WIDTH-1:0] o_lo,
  output logic [2*WIDTH-1:0] o_sum,
  output logic [2*WIDTH-1:0] o_carry
);

  localparam int PW = 2 * WIDTH;

  // Bit k set for every column that is approximated in approximate mode.
  function automatic logic [PW-1:0] lo_mask();
    logic [PW-1:0] m;
    for (int k = 0; k < PW; k++) begin
      m[k] = (k < APPROX_COLS);
    end
    return m;
  endfunction

  localparam logic [PW-1:0] LO_MASK = lo_mask();

  // 3:2 compressor across whole rows; result packed as {carry, sum}.
  // The carry bit shifted out of the top is dropped: the exact product always
  // fits in PW bits, so the modular sum stays correct.
  function automatic logic [2*PW-1:0] csa(
    input logic [PW-1:0] x,
    input logic [PW-1:0] y,
    input logic [PW-1:0] z
  );
    logic [PW-1:0] s;
    logic [PW-1:0] c;
    s = x ^ y ^ z;
    c = ((x & y) | (x & z) | (y & z)) << 1;
    return {c, s};
  endfunction

  logic [PW-1:0] w_pp_row [WIDTH];
  logic [PW-1:0] w_lo_or;
  logic          w_approx;

  assign w_approx = (i_mode == MODE_APPROX);

  // Partial-product rows (row i = a*b[i] shifted to column i) and their OR.
  always_comb begin
    w_lo_or = {PW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      w_pp_row[i] = {{WIDTH{1'b0}}, (i_a & {WIDTH{i_b[i]}})} << i;
      w_lo_or     = w_lo_or | w_pp_row[i];
    end
  end

  // Low OR columns plus linear carry-save reduction of the exact columns.
  always_comb begin
    logic [PW-1:0]   v_keep;
    logic [PW-1:0]   v_s;
    logic [PW-1:0]   v_c;
    logic [2*PW-1:0] v_cs;
    if (w_approx) begin
      v_keep = ~LO_MASK;
      o_lo   = w_lo_or & LO_MASK;
    end else begin
      v_keep = {PW{1'b1}};
      o_lo   = {PW{1'b0}};
    end
    v_s  = {PW{1'b0}};
    v_c  = {PW{1'b0}};
    v_cs = {(2*PW){1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      v_cs = csa(v_s, v_c, w_pp_row[i] & v_keep);
      v_s  = v_cs[PW-1:0];
      v_c  = v_cs[2*PW-1:PW];
    end
    o_sum   = v_s;
    o_carry = v_c;
  end

endmodule

// File: rtl/approx_mul_pipe.sv
// ---------------------------------------------------------------------------
// approx_mul_pipe
// Three-stage pipelined unsigned WIDTHxWIDTH multiplier with a per-operation
// exact / lower-part-OR approximate mode and an opaque tag sideband.
//   S1: operand register   S2: partial products + CSA rows   S3: final add
// All stages advance together when the output is empty or being accepted;
// bubbles travel with the pipeline and are not collapsed.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready = pipeline advance)
//   in_a, in_b            : operands (WIDTH)
//   in_mode, in_tag       : mode (0 exact, 1 approx), tag (TAG_W)
//   out_valid / out_ready : result handshake
//   out_result            : product (2*WIDTH)
//   out_mode, out_tag     : mode and tag of the result
//   busy                  : any stage holds a valid operation
// ---------------------------------------------------------------------------
module approx_mul_pipe
  import approx_mul_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 4,
  parameter int TAG_W       = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               out_mode,
  output logic [TAG_W-1:0]   out_tag,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  logic             w_en;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_mode;
  logic [TAG_W-1:0] r_s1_tag;

  logic [PW-1:0]    w_lo;
  logic [PW-1:0]    w_sum;
  logic [PW-1:0]    w_carry;

  logic             r_s2_valid;
  logic [PW-1:0]    r_s2_lo;
  logic [PW-1:0]    r_s2_sum;
  logic [PW-1:0]    r_s2_carry;
  logic             r_s2_mode;
  logic [TAG_W-1:0] r_s2_tag;

  logic [PW-1:0]    w_final;

  logic             r_out_valid;
  logic [PW-1:0]    r_out_result;
  logic             r_out_mode;
  logic [TAG_W-1:0] r_out_tag;

  // Whole pipeline moves when the output slot is free or being drained.
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  // Stage 1: capture operands. Payload only loads with a valid op so that
  // undriven operands on idle cycles never enter the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= {WIDTH{1'b0}};
      r_s1_b     <= {WIDTH{1'b0}};
      r_s1_mode  <= 1'b0;
      r_s1_tag   <= {TAG_W{1'b0}};
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a    <= in_a;
        r_s1_b    <= in_b;
        r_s1_mode <= in_mode;
        r_s1_tag  <= in_tag;
      end
    end
  end

  approx_col_reduce #(
    .WIDTH       (WIDTH),
    .APPROX_COLS (APPROX_COLS)
  ) u_reduce (
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_mode  (r_s1_mode),
    .o_lo    (w_lo),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  // Stage 2: register the OR-compressed low part and the two CSA rows.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
      r_s2_lo    <= {PW{1'b0}};
      r_s2_sum   <= {PW{1'b0}};
      r_s2_carry <= {PW{1'b0}};
      r_s2_mode  <= 1'b0;
      r_s2_tag   <= {TAG_W{1'b0}};
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_lo    <= w_lo;
        r_s2_sum   <= w_sum;
        r_s2_carry <= w_carry;
        r_s2_mode  <= r_s1_mode;
        r_s2_tag   <= r_s1_tag;
      end
    end
  end

  // Exact columns never reach the low region in approx mode, so a plain OR
  // merges the two parts without interaction.
  assign w_final = (r_s2_sum + r_s2_carry) | r_s2_lo;

  // Stage 3: output register; holds while a result waits to be accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= {PW{1'b0}};
      r_out_mode   <= 1'b0;
      r_out_tag    <= {TAG_W{1'b0}};
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_result <= w_final;
        r_out_mode   <= r_s2_mode;
        r_out_tag    <= r_s2_tag;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_mode   = r_out_mode;
  assign out_tag    = r_out_tag;
  assign busy       = r_s1_valid || r_s2_valid || r_out_valid;

endmodule
